arcade_input_conditioner: RTL and testbench
===========================================

Name: arcade_input_conditioner

Overview:
- Sits between the joystick merge logic (USB, DB9MD or DB15 sources, OR-ed into one 16-bit word) and the berzerk core's discrete control inputs.
- Synchronises the raw word into clk_sys, debounces each used bit and optionally cleans opposing directions.
- Turns a held coin button into exactly one fixed-width coin pulse.
- Turns pause presses into single-cycle toggle requests for the pause system.

Parameters:
- DEBOUNCE_CYC, 200000, cycles a raw bit must differ stably from its debounced value before the output changes (5 ms at 40 MHz); legal range ≥1.
- COIN_PULSE_CYC, 4000000, width of the coin output pulse in cycles (100 ms).
- COIN_GAP_CYC, 4000000, mandatory low time after each coin pulse in cycles.
- SOCD_CLEAN, 1, 1 = up+down or left+right pressed together both read as released; 0 = pass through.

Ports:
- clk_sys  in  1  system clock, 40 MHz
- reset  in  1  synchronous, active-high
- joy_raw  in  16  merged controls: 0 R, 1 L, 2 D, 3 U, 4 fire, 5 start1, 6 start2, 7 coin, 8 pause; bits 15:9 ignored; may be asynchronous to clk_sys
- dir_fire  out  5  debounced {fire,U,D,L,R}, after SOCD cleaning
- start1  out  1  debounced level
- start2  out  1  debounced level
- coin_pulse  out  1  shaped coin pulse to the core
- pause_toggle  out  1  one-cycle pulse per debounced pause press
- coin_count  out  8  coin pulses issued since reset, wraps 255→0

Behaviour:
- Clock and reset:
  - One clock, clk_sys. Reset is synchronous and active-high, named reset.
  - While reset is high, on every edge, all of the following are cleared to 0: all outputs, synchroniser flops, debounce counters and states, pause edge register, coin_count. The coin FSM goes to IDLE.
  - Reset asserted mid-pulse: coin_pulse is 0 from the first edge with reset high.
- Synchroniser:
  - Bits 8:0 pass through a 2-flop synchroniser.
  - raw_s(t) = joy_raw(t-2).
- Debounce, per bit:
  - State: db (1 bit) and cnt (width clog2(DEBOUNCE_CYC+1)).
  - raw_s==db → cnt<=0.
  - raw_s!=db and cnt==DEBOUNCE_CYC-1 → db<=raw_s, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - Any bounce back to db restarts the count.
  - Latency: a clean edge on joy_raw appears on db 2+DEBOUNCE_CYC edges later. Pulses shorter than DEBOUNCE_CYC cycles are fully rejected.
- SOCD cleaning:
  - Combinational on db.
  - With SOCD_CLEAN=1: U&D both 1 → both outputs 0; L&R both 1 → both 0.
  - dir_fire, start1 and start2 are registered, adding 1 cycle. Total input-to-output latency is DEBOUNCE_CYC+3 cycles.
- Pause:
  - pause_toggle = db_pause & ~db_pause_q, registered, so it is high for exactly one cycle per press.
  - Holding pause gives no repeat.
- Coin FSM, states IDLE, PULSE, GAP, HOLD:
  - IDLE: on rising edge of db_coin → PULSE; coin_count += 1 in the same cycle.
  - PULSE: coin_pulse=1 for exactly COIN_PULSE_CYC cycles, then → GAP.
  - GAP: coin_pulse=0 for exactly COIN_GAP_CYC cycles. At the end: db_coin=1 → HOLD, else → IDLE.
  - HOLD: → IDLE when db_coin=0. A button held indefinitely yields exactly one pulse.
  - Presses during PULSE or GAP are ignored; no queueing.
  - The rising-edge detector runs in all states. A release-and-repress landing inside GAP is therefore lost, and the press must be repeated after IDLE.
  - Single shared counter, width clog2(max(COIN_PULSE_CYC,COIN_GAP_CYC)+1), reloaded on each state entry.
- Width rules: all counters unsigned; no counter wraps except coin_count.

Decomposition:
- Package arcade_input_pkg:
  - bit-index localparams (JB_R=0 … JB_PAUSE=8);
  - coin_state_t enum {IDLE, PULSE, GAP, HOLD}.
- Sub-module input_debounce: one bit, parameter DEBOUNCE_CYC; inputs clk_sys, reset, raw_s; output db. Instantiated 9 times by generate.
- Synchroniser, SOCD logic, pause edge detector and coin FSM stay in the top module.

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, COIN_PULSE_CYC=8, COIN_GAP_CYC=6, SOCD_CLEAN=1.
1. Fire bit 4 set at cycle 0 and held → dir_fire=5'b10000 from cycle 7 (2+4+1). Release → cleared 7 cycles after release.
2. Bounce: bit 0 high for 3 cycles, low 1, high 3, low → dir_fire[0] never goes 1. Then held 10 cycles → goes 1 at the expected latency.
3. Joy_raw=0x000C (U+D) held → dir_fire[3:2]=00. Joy_raw=0x0008 → dir_fire=5'b01000.
4. Coin held 100 cycles → coin_pulse high for exactly 8 consecutive cycles, once; coin_count=1. Release, re-press after IDLE → second 8-cycle pulse; coin_count=2.
5. Pause held 50 cycles, twice → pause_toggle high exactly 2 single cycles.
6. Reset asserted at the 3rd cycle of a coin pulse → coin_pulse=0 and coin_count=0 after that edge. With coin still held, a new pulse starts DEBOUNCE_CYC+3 cycles after reset deasserts.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared bit indices and coin FSM state type for the arcade input conditioner.
package arcade_input_pkg;

  localparam int unsigned JB_R      = 0;
  localparam int unsigned JB_L      = 1;
  localparam int unsigned JB_D      = 2;
  localparam int unsigned JB_U      = 3;
  localparam int unsigned JB_FIRE   = 4;
  localparam int unsigned JB_START1 = 5;
  localparam int unsigned JB_START2 = 6;
  localparam int unsigned JB_COIN   = 7;
  localparam int unsigned JB_PAUSE  = 8;

  localparam int unsigned NUM_USED  = 9;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    HOLD
  } coin_state_t;

endpackage

// File: rtl/input_debounce.sv
// Single-bit debouncer: output follows the synchronised input only after it has
// differed stably for DEBOUNCE_CYC cycles.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 200000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw_s,
  output logic db
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (raw_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
      db_d  = raw_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/arcade_input_conditioner.sv
// Synchronises, debounces and shapes the merged joystick word into the core's
// direction/fire/start levels, a fixed-width coin pulse and pause toggle requests.
module arcade_input_conditioner
  import arcade_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC   = 200000,
  parameter int unsigned COIN_PULSE_CYC = 4000000,
  parameter int unsigned COIN_GAP_CYC   = 4000000,
  parameter bit          SOCD_CLEAN     = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joy_raw,
  output logic [4:0]  dir_fire,
  output logic        start1,
  output logic        start2,
  output logic        coin_pulse,
  output logic        pause_toggle,
  output logic [7:0]  coin_count
);

  localparam int unsigned CoinMax = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC
                                                                     : COIN_GAP_CYC;
  localparam int unsigned CoinW   = $clog2(CoinMax + 1);

  logic unused_hi;
  assign unused_hi = ^joy_raw[15:9];

  logic [NUM_USED-1:0] sync1_q, sync2_q, db;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= joy_raw[NUM_USED-1:0];
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_USED; i++) begin : g_db
    input_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk_sys(clk_sys),
      .reset  (reset),
      .raw_s  (sync2_q[i]),
      .db     (db[i])
    );
  end

  // Opposing directions cancel so the core never sees an impossible stick position.
  logic up, dn, lf, rt;
  always_comb begin
    up = db[JB_U];
    dn = db[JB_D];
    lf = db[JB_L];
    rt = db[JB_R];
    if (SOCD_CLEAN && db[JB_U] && db[JB_D]) begin
      up = 1'b0;
      dn = 1'b0;
    end
    if (SOCD_CLEAN && db[JB_L] && db[JB_R]) begin
      lf = 1'b0;
      rt = 1'b0;
    end
  end

  logic [4:0] dir_fire_q;
  logic       start1_q, start2_q;
  logic       pause_prev_q, pause_toggle_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir_fire_q     <= '0;
      start1_q       <= 1'b0;
      start2_q       <= 1'b0;
      pause_prev_q   <= 1'b0;
      pause_toggle_q <= 1'b0;
    end else begin
      dir_fire_q     <= {db[JB_FIRE], up, dn, lf, rt};
      start1_q       <= db[JB_START1];
      start2_q       <= db[JB_START2];
      pause_prev_q   <= db[JB_PAUSE];
      pause_toggle_q <= db[JB_PAUSE] & ~pause_prev_q;
    end
  end

  assign dir_fire     = dir_fire_q;
  assign start1       = start1_q;
  assign start2       = start2_q;
  assign pause_toggle = pause_toggle_q;

  // Coin FSM: one shared down-counter, reloaded on entry to PULSE and GAP.
  coin_state_t      state_q, state_d;
  logic [CoinW-1:0] ccnt_q, ccnt_d;
  logic [7:0]       coin_count_q, coin_count_d;
  logic             coin_prev_q;
  logic             coin_rise;

  assign coin_rise = db[JB_COIN] & ~coin_prev_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      ccnt_q       <= '0;
      coin_count_q <= '0;
      coin_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ccnt_q       <= ccnt_d;
      coin_count_q <= coin_count_d;
      coin_prev_q  <= db[JB_COIN];
    end
  end

  always_comb begin
    state_d      = state_q;
    ccnt_d       = ccnt_q;
    coin_count_d = coin_count_q;
    unique case (state_q)
      IDLE: begin
        if (coin_rise) begin
          state_d      = PULSE;
          ccnt_d       = CoinW'(COIN_PULSE_CYC - 1);
          coin_count_d = coin_count_q + 8'd1;
        end
      end
      PULSE: begin
        if (ccnt_q == '0) begin
          state_d = GAP;
          ccnt_d  = CoinW'(COIN_GAP_CYC - 1);
        end else begin
          ccnt_d = ccnt_q - CoinW'(1);
        end
      end
      GAP: begin
        if (ccnt_q == '0) begin
          state_d = db[JB_COIN] ? HOLD : IDLE;
          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q - CoinW'(1);
        end
      end
      HOLD: begin
        if (!db[JB_COIN]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coin_pulse = (state_q == PULSE);
  end

  assign coin_count = coin_count_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed bench for arcade_input_conditioner: static vector table plus timed
// sequences for latency, bounce rejection, coin shaping, pause and reset.
module tb_arcade_input_conditioner;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] joy_raw = 16'h0000;
  logic [4:0]  dir_fire;
  logic        start1, start2, coin_pulse, pause_toggle;
  logic [7:0]  coin_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_conditioner #(
    .DEBOUNCE_CYC  (4),
    .COIN_PULSE_CYC(8),
    .COIN_GAP_CYC  (6),
    .SOCD_CLEAN    (1'b1)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .joy_raw     (joy_raw),
    .dir_fire    (dir_fire),
    .start1      (start1),
    .start2      (start2),
    .coin_pulse  (coin_pulse),
    .pause_toggle(pause_toggle),
    .coin_count  (coin_count)
  );

  typedef struct {
    logic [15:0] joy;
    logic [4:0]  dir;
    logic        s1;
    logic        s2;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    joy_raw = 16'h0000;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    int unsigned highs, rises, first_hi, run, max_run, bounce_hi;
    logic        prev;
    logic        bounce_pat[14];

    vecs[0]  = '{16'h0000, 5'b00000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0010, 5'b10000, 1'b0, 1'b0};
    vecs[2]  = '{16'h000C, 5'b00000, 1'b0, 1'b0};
    vecs[3]  = '{16'h0008, 5'b01000, 1'b0, 1'b0};
    vecs[4]  = '{16'h0003, 5'b00000, 1'b0, 1'b0};
    vecs[5]  = '{16'h0005, 5'b00101, 1'b0, 1'b0};
    vecs[6]  = '{16'h0006, 5'b00110, 1'b0, 1'b0};
    vecs[7]  = '{16'h001F, 5'b10000, 1'b0, 1'b0};
    vecs[8]  = '{16'h0020, 5'b00000, 1'b1, 1'b0};
    vecs[9]  = '{16'h0040, 5'b00000, 1'b0, 1'b1};
    vecs[10] = '{16'h0079, 5'b11001, 1'b1, 1'b1};
    vecs[11] = '{16'hFE00, 5'b00000, 1'b0, 1'b0};

    // Reset state, checked while reset is still asserted.
    reset = 1'b1;
    joy_raw = 16'h01FF;
    repeat (3) tick();
    check("rst_dir_fire", dir_fire, 0);
    check("rst_start1", start1, 0);
    check("rst_start2", start2, 0);
    check("rst_coin_pulse", coin_pulse, 0);
    check("rst_pause_toggle", pause_toggle, 0);
    check("rst_coin_count", coin_count, 0);

    // Static vector table.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      joy_raw = vecs[v].joy;
      repeat (10) tick();
      check($sformatf("vec%0d_dir_fire", v), dir_fire, vecs[v].dir);
      check($sformatf("vec%0d_start1", v), start1, vecs[v].s1);
      check($sformatf("vec%0d_start2", v), start2, vecs[v].s2);
      check($sformatf("vec%0d_coin_pulse", v), coin_pulse, 0);
    end

    // Fire latency: press and release both take DEBOUNCE_CYC+3 = 7 edges.
    do_reset();
    joy_raw = 16'h0010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("fire_rise_c%0d", c), dir_fire, (c >= 7) ? 5'b10000 : 5'b00000);
    end
    repeat (3) tick();
    joy_raw = 16'h0000;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("fire_fall_c%0d", c), dir_fire, (c >= 7) ? 5'b00000 : 5'b10000);
    end

    // Bounce on R: 3 high, 1 low, 3 high, low -> never accepted.
    do_reset();
    bounce_pat = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    bounce_hi = 0;
    for (int c = 0; c < 14; c++) begin
      joy_raw = {15'd0, bounce_pat[c]};
      tick();
      if (dir_fire[0]) bounce_hi++;
    end
    check("bounce_rejected", bounce_hi, 0);
    joy_raw = 16'h0001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("r_held_c%0d", c), dir_fire[0], (c >= 7) ? 1 : 0);
    end

    // Coin held 100 cycles: one 8-cycle pulse starting at edge 7.
    do_reset();
    joy_raw = 16'h0080;
    highs = 0; rises = 0; first_hi = 0; prev = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (coin_pulse) highs++;
      if (coin_pulse && !prev) begin
        rises++;
        if (first_hi == 0) first_hi = c;
      end
      prev = coin_pulse;
    end
    check("coin1_high_cycles", highs, 8);
    check("coin1_pulses", rises, 1);
    check("coin1_start_edge", first_hi, 7);
    check("coin1_count", coin_count, 1);
    joy_raw = 16'h0000;
    repeat (20) tick();
    joy_raw = 16'h0080;
    highs = 0; rises = 0; first_hi = 0; prev = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (coin_pulse) highs++;
      if (coin_pulse && !prev) begin
        rises++;
        if (first_hi == 0) first_hi = c;
      end
      prev = coin_pulse;
    end
    check("coin2_high_cycles", highs, 8);
    check("coin2_pulses", rises, 1);
    check("coin2_start_edge", first_hi, 7);
    check("coin2_count", coin_count, 2);
    joy_raw = 16'h0000;
    repeat (20) tick();

    // Pause held twice: exactly two single-cycle toggles.
    do_reset();
    highs = 0; run = 0; max_run = 0;
    for (int p = 0; p < 2; p++) begin
      joy_raw = 16'h0100;
      for (int c = 0; c < 50; c++) begin
        tick();
        if (pause_toggle) begin
          highs++;
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
      joy_raw = 16'h0000;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (pause_toggle) highs++;
      end
    end
    check("pause_toggles", highs, 2);
    check("pause_max_run", max_run, 1);

    // Reset in the 3rd pulse cycle, coin still held.
    do_reset();
    joy_raw = 16'h0080;
    repeat (7) tick();
    check("rstmid_pulse_c7", coin_pulse, 1);
    repeat (2) tick();
    check("rstmid_pulse_c9", coin_pulse, 1);
    reset = 1'b1;
    tick();
    check("rstmid_pulse_cleared", coin_pulse, 0);
    check("rstmid_count_cleared", coin_count, 0);
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("rstmid_repulse_c%0d", c), coin_pulse, (c >= 7) ? 1 : 0);
    end
    check("rstmid_count_after", coin_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
